vmp_txn_controller: RTL and testbench

Sequential transaction controller for the vending machine.
- Accumulates inserted coins into a credit register.
- Owns the 4-slot goods table (per-slot stock and price).
- Runs one purchase at a time: check, per-unit dispense pulses, change return.

---
 rtl/vmp_txn_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_vmp_txn_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vmp_txn_controller.sv
// Vending machine transaction controller: coin credit, goods table,
// purchase check, paced dispense pulses and change return.
module vmp_txn_controller #(
  parameter int unsigned CREDIT_W     = 6,
  parameter int unsigned TIMEOUT_CYC  = 255,
  parameter int unsigned DISPENSE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_slot,
  input  logic [2:0]          cfg_stock,
  input  logic [2:0]          cfg_price,
  input  logic                coin_valid,
  input  logic [3:0]          coin_value,
  input  logic                sel_valid,
  input  logic [1:0]          sel_item,
  input  logic [2:0]          sel_qty,
  input  logic                cancel,
  input  logic [1:0]          stat_slot,
  output logic [2:0]          stat_stock,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                dispense_valid,
  output logic [1:0]          dispense_item,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic                result_valid,
  output logic                result_ok,
  output logic [1:0]          err_code
);

  localparam int unsigned SUM_W  = CREDIT_W + 1;
  localparam int unsigned COST_W = 6;
  localparam int unsigned CMP_W  = (CREDIT_W > COST_W) ? CREDIT_W : COST_W;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GAP_W  = (DISPENSE_CYC > 1) ? $clog2(DISPENSE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_VEND,
    S_CHANGE
  } state_t;

  state_t              state_q, state_n;
  logic [3:0][2:0]     stock_q, stock_n;
  logic [3:0][2:0]     price_q, price_n;
  logic [TMR_W-1:0]    timer_q, timer_n;
  logic [1:0]          item_q, item_n;
  logic [2:0]          qty_q, qty_n;
  logic [2:0]          cnt_q, cnt_n;
  logic [GAP_W-1:0]    gap_q, gap_n;
  logic                abort_q, abort_n;
  logic [CREDIT_W-1:0] credit_n;

  logic                coin_reject_n;
  logic                dispense_valid_n;
  logic [1:0]          dispense_item_n;
  logic                change_valid_n;
  logic [CREDIT_W-1:0] change_amount_n;
  logic                result_valid_n;
  logic                result_ok_n;
  logic [1:0]          err_code_n;

  logic [SUM_W-1:0]    coin_sum;
  logic                coin_fits;
  logic [COST_W-1:0]   cost;
  logic                timeout;

  // Status read and busy flag straight from registered state
  assign stat_stock = stock_q[stat_slot];
  assign busy       = (state_q == S_CHECK) || (state_q == S_VEND) || (state_q == S_CHANGE);

  // Coin headroom, purchase cost and idle timeout
  always_comb begin
    coin_sum  = SUM_W'(credit) + SUM_W'(coin_value);
    coin_fits = ~coin_sum[CREDIT_W];
    cost      = COST_W'(qty_q) * COST_W'(price_q[item_q]);
    timeout   = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
  end

  // Next-state, datapath and output pulse logic
  always_comb begin
    state_n          = state_q;
    stock_n          = stock_q;
    price_n          = price_q;
    timer_n          = timer_q;
    item_n           = item_q;
    qty_n            = qty_q;
    cnt_n            = cnt_q;
    gap_n            = gap_q;
    abort_n          = abort_q;
    credit_n         = credit;
    coin_reject_n    = 1'b0;
    dispense_valid_n = 1'b0;
    dispense_item_n  = 2'b00;
    change_valid_n   = 1'b0;
    change_amount_n  = '0;
    result_valid_n   = 1'b0;
    result_ok_n      = 1'b0;
    err_code_n       = 2'b00;

    case (state_q)
      S_IDLE: begin
        timer_n = '0;
        if (cfg_we) begin
          stock_n[cfg_slot] = cfg_stock;
          price_n[cfg_slot] = cfg_price;
        end
        if (coin_valid) begin
          if (coin_fits) begin
            credit_n = coin_sum[CREDIT_W-1:0];
            state_n  = S_COLLECT;
          end else begin
            coin_reject_n = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        if (coin_valid && coin_fits) begin
          credit_n = coin_sum[CREDIT_W-1:0];
          timer_n  = '0;
        end else begin
          coin_reject_n = coin_valid;
          timer_n       = timer_q + TMR_W'(1);
        end
        if (cancel || (!(coin_valid && coin_fits) && timeout)) begin
          abort_n = 1'b1;
          state_n = S_CHANGE;
        end else if (sel_valid) begin
          item_n  = sel_item;
          qty_n   = sel_qty;
          state_n = S_CHECK;
        end
      end

      S_CHECK: begin
        coin_reject_n = coin_valid;
        if ((qty_q == 3'd0) || (qty_q > stock_q[item_q])) begin
          result_valid_n = 1'b1;
          err_code_n     = 2'b01;
          timer_n        = '0;
          state_n        = S_COLLECT;
        end else if (CMP_W'(cost) > CMP_W'(credit)) begin
          result_valid_n = 1'b1;
          err_code_n     = 2'b10;
          timer_n        = '0;
          state_n        = S_COLLECT;
        end else begin
          stock_n[item_q] = stock_q[item_q] - qty_q;
          credit_n        = credit - CREDIT_W'(cost);
          cnt_n           = qty_q;
          gap_n           = '0;
          state_n         = S_VEND;
        end
      end

      S_VEND: begin
        coin_reject_n = coin_valid;
        if (cnt_q == 3'd0) begin
          result_valid_n = 1'b1;
          result_ok_n    = 1'b1;
          abort_n        = 1'b0;
          state_n        = S_CHANGE;
        end else if (gap_q == '0) begin
          dispense_valid_n = 1'b1;
          dispense_item_n  = item_q;
          cnt_n            = cnt_q - 3'd1;
          gap_n            = GAP_W'(DISPENSE_CYC - 1);
        end else begin
          gap_n = gap_q - GAP_W'(1);
        end
      end

      S_CHANGE: begin
        coin_reject_n = coin_valid;
        if (credit != '0) begin
          change_valid_n  = 1'b1;
          change_amount_n = credit;
        end
        if (abort_q) begin
          result_valid_n = 1'b1;
          err_code_n     = 2'b11;
        end
        credit_n = '0;
        abort_n  = 1'b0;
        timer_n  = '0;
        state_n  = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  // State, table, credit and registered output pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      stock_q        <= '0;
      price_q        <= '0;
      timer_q        <= '0;
      item_q         <= '0;
      qty_q          <= '0;
      cnt_q          <= '0;
      gap_q          <= '0;
      abort_q        <= 1'b0;
      credit         <= '0;
      coin_reject    <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_item  <= '0;
      change_valid   <= 1'b0;
      change_amount  <= '0;
      result_valid   <= 1'b0;
      result_ok      <= 1'b0;
      err_code       <= '0;
    end else begin
      state_q        <= state_n;
      stock_q        <= stock_n;
      price_q        <= price_n;
      timer_q        <= timer_n;
      item_q         <= item_n;
      qty_q          <= qty_n;
      cnt_q          <= cnt_n;
      gap_q          <= gap_n;
      abort_q        <= abort_n;
      credit         <= credit_n;
      coin_reject    <= coin_reject_n;
      dispense_valid <= dispense_valid_n;
      dispense_item  <= dispense_item_n;
      change_valid   <= change_valid_n;
      change_amount  <= change_amount_n;
      result_valid   <= result_valid_n;
      result_ok      <= result_ok_n;
      err_code       <= err_code_n;
    end
  end

endmodule

// File: tb/tb_vmp_txn_controller.sv
// Directed bench for vmp_txn_controller with hand-computed expectations.
module tb_vmp_txn_controller;

  logic       clk, rst;
  logic       cfg_we;
  logic [1:0] cfg_slot;
  logic [2:0] cfg_stock, cfg_price;
  logic       coin_valid;
  logic [3:0] coin_value;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic [2:0] sel_qty;
  logic       cancel;
  logic [1:0] stat_slot;
  logic [2:0] stat_stock;
  logic [5:0] credit;
  logic       busy, coin_reject, dispense_valid;
  logic [1:0] dispense_item;
  logic       change_valid;
  logic [5:0] change_amount;
  logic       result_valid, result_ok;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  vmp_txn_controller #(.CREDIT_W(6), .TIMEOUT_CYC(255), .DISPENSE_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_stock(cfg_stock), .cfg_price(cfg_price),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_item(sel_item), .sel_qty(sel_qty),
    .cancel(cancel), .stat_slot(stat_slot), .stat_stock(stat_stock),
    .credit(credit), .busy(busy), .coin_reject(coin_reject),
    .dispense_valid(dispense_valid), .dispense_item(dispense_item),
    .change_valid(change_valid), .change_amount(change_amount),
    .result_valid(result_valid), .result_ok(result_ok), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [1:0] s, input logic [2:0] st, input logic [2:0] pr);
    cfg_we = 1'b1; cfg_slot = s; cfg_stock = st; cfg_price = pr;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_coin(input logic [3:0] v);
    coin_valid = 1'b1; coin_value = v;
    tick();
    coin_valid = 1'b0; coin_value = 4'd0;
  endtask

  task automatic do_sel(input logic [1:0] it, input logic [2:0] q);
    sel_valid = 1'b1; sel_item = it; sel_qty = q;
    tick();
    sel_valid = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    logic seen;

    rst = 1'b1; cfg_we = 1'b0; cfg_slot = '0; cfg_stock = '0; cfg_price = '0;
    coin_valid = 1'b0; coin_value = '0; sel_valid = 1'b0; sel_item = '0; sel_qty = '0;
    cancel = 1'b0; stat_slot = 2'd1;
    #12;
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result_valid, 0);
    chk("rst_stock", stat_stock, 0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Basic purchase: two units of slot 1 at price 3 with credit 8
    do_cfg(2'd1, 3'd5, 3'd3);
    chk("s1_cfg_stock", stat_stock, 5);
    do_coin(4'd4);
    chk("s1_credit4", credit, 4);
    do_coin(4'd4);
    chk("s1_credit8", credit, 8);
    do_sel(2'd1, 3'd2);
    chk("s1_busy_check", busy, 1);
    tick();
    chk("s1_credit_after_cost", credit, 2);
    chk("s1_stock_dec", stat_stock, 3);
    chk("s1_no_result_yet", result_valid, 0);
    tick();
    chk("s1_pulse1", dispense_valid, 1);
    chk("s1_pulse1_item", dispense_item, 1);
    coin_valid = 1'b1; coin_value = 4'd1;
    tick();
    coin_valid = 1'b0; coin_value = 4'd0;
    chk("s1_vend_coin_reject", coin_reject, 1);
    chk("s1_vend_credit_kept", credit, 2);
    chk("s1_gap0", dispense_valid, 0);
    repeat (2) begin
      tick();
      chk("s1_gap", dispense_valid, 0);
    end
    tick();
    chk("s1_pulse2", dispense_valid, 1);
    chk("s1_pulse2_item", dispense_item, 1);
    tick();
    chk("s1_result_valid", result_valid, 1);
    chk("s1_result_ok", result_ok, 1);
    chk("s1_result_err", err_code, 0);
    chk("s1_no_extra_pulse", dispense_valid, 0);
    tick();
    chk("s1_change_valid", change_valid, 1);
    chk("s1_change_amount", change_amount, 2);
    chk("s1_credit_zero", credit, 0);
    chk("s1_idle", busy, 0);

    // Insufficient credit, then top up and buy with exact credit
    do_cfg(2'd1, 3'd5, 3'd3);
    do_coin(4'd5);
    do_sel(2'd1, 3'd2);
    tick();
    chk("s2_result_valid", result_valid, 1);
    chk("s2_result_ok", result_ok, 0);
    chk("s2_err10", err_code, 2);
    chk("s2_credit_kept", credit, 5);
    chk("s2_collect", busy, 0);
    do_coin(4'd1);
    chk("s2_credit6", credit, 6);
    do_sel(2'd1, 3'd2);
    tick();
    chk("s2_credit_spent", credit, 0);
    tick();
    chk("s2_pulse1", dispense_valid, 1);
    repeat (3) tick();
    tick();
    chk("s2_pulse2", dispense_valid, 1);
    tick();
    chk("s2_result_ok", result_ok, 1);
    tick();
    chk("s2_no_change", change_valid, 0);
    chk("s2_idle", busy, 0);
    chk("s2_stock3", stat_stock, 3);

    // Invalid quantity, cfg ignored in COLLECT, cancel refund
    do_cfg(2'd1, 3'd5, 3'd3);
    do_coin(4'd10);
    do_sel(2'd1, 3'd6);
    tick();
    chk("s3_qty6_result", result_valid, 1);
    chk("s3_qty6_err", err_code, 1);
    chk("s3_qty6_stock", stat_stock, 5);
    do_sel(2'd1, 3'd0);
    tick();
    chk("s3_qty0_result", result_valid, 1);
    chk("s3_qty0_err", err_code, 1);
    chk("s3_qty0_credit", credit, 10);
    do_cfg(2'd2, 3'd7, 3'd1);
    stat_slot = 2'd2;
    #1;
    chk("s3_cfg_ignored", stat_stock, 0);
    stat_slot = 2'd1;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
    chk("s3_cancel_change", change_valid, 1);
    chk("s3_cancel_amount", change_amount, 10);
    chk("s3_cancel_result", result_valid, 1);
    chk("s3_cancel_ok", result_ok, 0);
    chk("s3_cancel_err", err_code, 3);

    // Idle timeout refund
    do_coin(4'd3);
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 400 && !seen; i++) begin
      tick();
      if (change_valid) begin
        seen = 1'b1;
        n = i;
      end
    end
    chk("s4_timeout_seen", seen, 1);
    chk("s4_timeout_cycles", n, 256);
    chk("s4_timeout_amount", change_amount, 3);
    chk("s4_timeout_result", result_valid, 1);
    chk("s4_timeout_err", err_code, 3);
    chk("s4_timeout_credit", credit, 0);

    // Cancel in the same cycle as a coin refunds both
    do_coin(4'd3);
    coin_valid = 1'b1; coin_value = 4'd2; cancel = 1'b1;
    tick();
    coin_valid = 1'b0; coin_value = 4'd0; cancel = 1'b0;
    chk("s4_cc_credit", credit, 5);
    chk("s4_cc_busy", busy, 1);
    tick();
    chk("s4_cc_change", change_valid, 1);
    chk("s4_cc_amount", change_amount, 5);
    chk("s4_cc_err", err_code, 3);

    // Credit overflow rejects the coin
    repeat (4) do_coin(4'd15);
    chk("s5_credit60", credit, 60);
    do_coin(4'd8);
    chk("s5_reject", coin_reject, 1);
    chk("s5_credit_kept", credit, 60);
    tick();
    chk("s5_reject_one_cycle", coin_reject, 0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();
    chk("s5_refund60", change_amount, 60);

    // Asynchronous reset in the middle of a three-unit vend
    do_cfg(2'd0, 3'd5, 3'd1);
    stat_slot = 2'd0;
    do_coin(4'd5);
    do_sel(2'd0, 3'd3);
    tick();
    chk("s6_credit2", credit, 2);
    tick();
    chk("s6_pulse1", dispense_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_dispense", dispense_valid, 0);
    chk("s6_rst_credit", credit, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_stock", stat_stock, 0);
    #3 rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      tick();
      if (dispense_valid) pulses++;
    end
    chk("s6_no_pulses", pulses, 0);
    chk("s6_credit_after", credit, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
